clk_div_prog: RTL

Runtime-programmable integer clock divider producing a 50 %-duty output for both odd and even divisors. It generalises the fixed divide-by-9 odd divider to any divisor from 2 to 2^W−1, with glitch-free divisor changes, a run enable and a period tick. It sits next to the clock source and feeds slow-clock domains and strobe generators.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_prog_if.sv | 23 ++
 rtl/clk_div_cnt.sv | 100 ++++++++++
 rtl/clk_div_prog.sv | 63 ++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable 50%-duty clock divider.
// Combinational helpers only; no latency, no backpressure.
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_st_t;

  // Number of input cycles the posedge duty flop stays high: ceil(n/2).
  function automatic logic [31:0] hi_cnt(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// Plain wires; no latency, no backpressure.
interface clk_div_prog_if #(
  parameter int W = 8
);
  logic         en;
  logic [W-1:0] div_val;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic         div_err;
  logic [W-1:0] div_cur;

  modport master (
    output en, div_val, div_load,
    input  clk_out, tick, div_err, div_cur
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_out, tick, div_err, div_cur
  );
endinterface

// File: rtl/clk_div_cnt.sv
// Period counter, run control and divisor load/apply for the clock divider.
// Next-state outputs are combinational from registers and inputs; no backpressure.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic [W-1:0] cnt_nxt,
  output logic         run_nxt,
  output logic [W-1:0] div_nxt,
  output logic         tick,
  output logic         div_err,
  output logic [W-1:0] div_cur
);

  typedef logic [W-1:0] div_t;
  localparam div_t DEF_DIV = div_t'(DEFAULT_DIV);
  localparam div_t ONE     = div_t'(1);
  localparam div_t MIN     = div_t'(MIN_DIV);

  run_st_t state;
  run_st_t state_nxt;
  div_t    cnt;
  div_t    div_act;
  div_t    div_pend;
  logic    pend_vld;
  logic    run;
  logic    wrap;
  logic    start;
  logic    load_ok;
  logic    load_bad;

  assign load_ok  = div_load & (div_val >= MIN);
  assign load_bad = div_load & (div_val <  MIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A stop request is only honoured at the wrap, so the period always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)          state_nxt = ST_RUN;
      ST_RUN:  if (wrap && !en) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run     = (state == ST_RUN);
    wrap    = run & (cnt == div_act - ONE);
    start   = ~run & en;
    tick    = wrap;
    run_nxt = (state_nxt == ST_RUN);
  end

  // A load arriving on the wrap cycle bypasses the pending slot.
  always_comb begin
    cnt_nxt = cnt;
    div_nxt = div_act;
    if (start || wrap) begin
      cnt_nxt = '0;
      if (load_ok)       div_nxt = div_val;
      else if (pend_vld) div_nxt = div_pend;
    end else if (run) begin
      cnt_nxt = cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      div_act  <= DEF_DIV;
      div_pend <= DEF_DIV;
      pend_vld <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_act <= div_nxt;
      if (start || wrap) begin
        pend_vld <= 1'b0;
      end else if (load_ok) begin
        div_pend <= div_val;
        pend_vld <= 1'b1;
      end
      if (load_bad) div_err <= 1'b1;
    end
  end

  assign div_cur = div_act;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider, N = 2..2^W-1; odd N uses a negedge flop.
// clk_out rises on the first posedge sampling en (odd N: following negedge); no backpressure.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 9
) (
  input  logic           clk,
  input  logic           rstn,
  clk_div_prog_if.slave  bus
);

  typedef logic [W-1:0] div_t;
  localparam div_t DEF_DIV = div_t'(DEFAULT_DIV);

  div_t cnt_nxt;
  div_t div_nxt;
  div_t hi_lim;
  logic run_nxt;
  logic p_q;
  logic n_q;
  logic odd_q;

  clk_div_cnt #(
    .W           (W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .en       (bus.en),
    .div_val  (bus.div_val),
    .div_load (bus.div_load),
    .cnt_nxt  (cnt_nxt),
    .run_nxt  (run_nxt),
    .div_nxt  (div_nxt),
    .tick     (bus.tick),
    .div_err  (bus.div_err),
    .div_cur  (bus.div_cur)
  );

  // ceil(N/2) never exceeds 2^(W-1), so it fits back into W bits.
  assign hi_lim = div_t'(hi_cnt(32'(div_nxt)));

  // div_nxt only moves at the wrap/start, so odd_q switches only at a period boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q   <= 1'b0;
      odd_q <= DEF_DIV[0];
    end else begin
      p_q   <= run_nxt & (cnt_nxt < hi_lim);
      odd_q <= div_nxt[0];
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) n_q <= 1'b0;
    else       n_q <= p_q;
  end

  assign bus.clk_out = odd_q ? (p_q & n_q) : p_q;

endmodule
